// File: rtl/cla32_clk_pkg.sv
// cla32_clk_pkg: shared width and lookahead group size for the registered CLA
package cla32_clk_pkg;
    localparam int WIDTH   = 32;
    localparam int CLA_GRP = 4;
endpackage

// File: rtl/cla32_clk_cla4.sv
// cla4: 4-bit combinational carry-lookahead adder group
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic [4:1] c;
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ {c[3:1], ci};
        co   = c[4];
    end
endmodule

// File: rtl/cla32_clk.sv
// cla32_clk: input-registered, output-registered carry-lookahead adder (2-cycle latency)
module cla32_clk #(
    parameter int WIDTH = cla32_clk_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    import cla32_clk_pkg::*;
    localparam int NG = WIDTH / CLA_GRP;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
    logic             ci_q, co_q, co_d;
    logic [NG:0]      gc;
    assign gc[0] = ci_q;
    for (genvar i = 0; i < NG; i++) begin : g_grp
        cla4 u_cla4 (
            .a  (a_q[i*CLA_GRP +: CLA_GRP]),
            .b  (b_q[i*CLA_GRP +: CLA_GRP]),
            .ci (gc[i]),
            .s  (s_d[i*CLA_GRP +: CLA_GRP]),
            .co (gc[i+1])
        );
    end
    assign co_d = gc[NG];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            ci_q <= 1'b0;
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            ci_q <= ci;
            s_q  <= s_d;
            co_q <= co_d;
        end
    end
    assign s  = s_q;
    assign co = co_q;
endmodule

// File: tb/tb_cla32_clk.sv
// tb_cla32_clk: scoreboard bench for the registered CLA against a+b+ci delayed two edges
module tb_cla32_clk;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, s;
    logic        ci, co;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    string       tag_q[$];

    cla32_clk dut (.clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .s(s), .co(co));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got co=%0b s=%08h, expected co=%0b s=%08h",
                     tag, got[32], got[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Result for inputs captured at one edge is compared just after the following edge.
    task automatic step(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        a  = av;
        b  = bv;
        ci = cv;
        @(posedge clk);
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {32'd0, cv});
        tag_q.push_back(tag);
        #1;
        if (exp_q.size() == 2) chk(tag_q.pop_front(), {co, s}, exp_q.pop_front());
    endtask

    task automatic pulse_reset(input int hold);
        rst = 1'b1;
        #1;
        chk("rst_async", {co, s}, 33'd0);
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("rst_held", {co, s}, 33'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a   = 32'hFFFF_FFFF;
        b   = 32'h0000_0001;
        ci  = 1'b1;
        #1;
        chk("rst_init", {co, s}, 33'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold", {co, s}, 33'd0);
        end
        rst = 1'b0;
        step("rst_release", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        step("full_chain",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        step("no_carry",    32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
        step("mixed",       32'h135F_A562, 32'h3561_4642, 1'b0);
        step("b2b_chain",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        step("b2b_nocarry", 32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
        step("b2b_mixed",   32'h135F_A562, 32'h3561_4642, 1'b0);
        step("grp_boundary", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        step("all_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        // Mid-stream reset with operations in flight.
        step("pre_rst", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        pulse_reset(2);
        step("post_rst0", 32'h8000_0000, 32'h8000_0000, 1'b0);
        step("post_rst1", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset($urandom_range(0, 3));
            step("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 1) chk(tag_q.pop_front(), {co, s}, exp_q.pop_front());
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
